// File: rtl/parity_arb_2ch_if.sv
// Bundled request/result signals for parity_arb_2ch.
// err_cnt0/err_cnt1 exist only when PARITY_ERR_CNT_EN is defined.
interface parity_arb_2ch_if #(parameter int CNT_W = 8);
  logic       in0_valid;
  logic       in0_ready;
  logic [8:0] in0_data;
  logic       in0_exp;
  logic       in0_odd;
  logic       in1_valid;
  logic       in1_ready;
  logic [8:0] in1_data;
  logic       in1_exp;
  logic       in1_odd;
  logic       out_valid;
  logic       out_ready;
  logic       out_ch;
  logic       out_ep;
  logic       out_op;
  logic       out_err;
  logic       cnt_clr;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt0;
  logic [CNT_W-1:0] err_cnt1;
`endif

  modport master (
    output in0_valid, in0_data, in0_exp, in0_odd,
    output in1_valid, in1_data, in1_exp, in1_odd,
    input  in0_ready, in1_ready,
    input  out_valid, out_ch, out_ep, out_op, out_err,
    output out_ready, cnt_clr
`ifdef PARITY_ERR_CNT_EN
    , input err_cnt0, err_cnt1
`endif
  );

  modport slave (
    input  in0_valid, in0_data, in0_exp, in0_odd,
    input  in1_valid, in1_data, in1_exp, in1_odd,
    output in0_ready, in1_ready,
    output out_valid, out_ch, out_ep, out_op, out_err,
    input  out_ready, cnt_clr
`ifdef PARITY_ERR_CNT_EN
    , output err_cnt0, err_cnt1
`endif
  );
endinterface

// File: rtl/parity_arb_2ch.sv
// Two-channel round-robin arbiter in front of a shared 9-bit parity generator/checker.
// Optional per-channel saturating error counters when PARITY_ERR_CNT_EN is defined.
module parity_arb_2ch #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  parity_arb_2ch_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant, grant_vld;
  logic       can_accept, accept;
  logic [8:0] sel_data;
  logic       sel_exp, sel_odd;
  logic       par_even, par_err;

  // Contention goes to the channel that did not win last time.
  always_comb begin
    grant_vld = bus.in0_valid | bus.in1_valid;
    if (bus.in0_valid && bus.in1_valid) grant = ~last_grant;
    else                                grant = bus.in1_valid;
  end

  assign can_accept    = (state == IDLE) | bus.out_ready;
  assign accept        = can_accept & grant_vld;
  assign bus.in0_ready = accept & ~grant;
  assign bus.in1_ready = accept & grant;
  assign bus.out_valid = (state == HOLD);

  always_comb begin
    sel_data = grant ? bus.in1_data : bus.in0_data;
    sel_exp  = grant ? bus.in1_exp  : bus.in0_exp;
    sel_odd  = grant ? bus.in1_odd  : bus.in0_odd;
    par_even = ^sel_data;
    par_err  = (sel_odd ? ~par_even : par_even) != sel_exp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (bus.out_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      bus.out_ch  <= 1'b0;
      bus.out_ep  <= 1'b0;
      bus.out_op  <= 1'b1;
      bus.out_err <= 1'b0;
    end else if (accept) begin
      last_grant  <= grant;
      bus.out_ch  <= grant;
      bus.out_ep  <= par_even;
      bus.out_op  <= ~par_even;
      bus.out_err <= par_err;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept && par_err) begin
      if (!grant && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
      if (grant  && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign bus.err_cnt0 = cnt0;
  assign bus.err_cnt1 = cnt1;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
`endif

endmodule

// File: tb/tb_parity_arb_2ch.sv
// Scoreboard bench for parity_arb_2ch; counter checks compile in with PARITY_ERR_CNT_EN.
module tb_parity_arb_2ch;

  localparam int CW = 2;

  typedef struct packed {
    logic ch;
    logic ep;
    logic op;
    logic err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  res_t          exp_q[$];
  logic          mdl_hold;
  logic          mdl_last;
  logic [CW-1:0] mdl_cnt0, mdl_cnt1;

  parity_arb_2ch_if #(.CNT_W(CW)) bus ();
  parity_arb_2ch #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(logic ch, logic [8:0] d, logic odd, logic ex);
    res_t r;
    r.ch  = ch;
    r.ep  = ^d;
    r.op  = ~(^d);
    r.err = ((odd ? r.op : r.ep) != ex);
    return r;
  endfunction

  function automatic logic mdl_gv();
    return (!mdl_hold || bus.out_ready) && (bus.in0_valid || bus.in1_valid);
  endfunction

  function automatic logic mdl_g();
    return (bus.in0_valid && bus.in1_valid) ? ~mdl_last : bus.in1_valid;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_hold = 1'b0;
    mdl_last = 1'b1;
    mdl_cnt0 = '0;
    mdl_cnt1 = '0;
  endtask

  // Advance one clock, updating the reference model with what the edge should do.
  task automatic tick();
    logic gv, g;
    res_t r;
    gv = mdl_gv();
    g  = mdl_g();
    r  = g ? mk(1'b1, bus.in1_data, bus.in1_odd, bus.in1_exp)
           : mk(1'b0, bus.in0_data, bus.in0_odd, bus.in0_exp);
    if (mdl_hold && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (gv) begin
      exp_q.push_back(r);
      mdl_hold = 1'b1;
      mdl_last = g;
    end else if (bus.out_ready) begin
      mdl_hold = 1'b0;
    end
    if (bus.cnt_clr) begin
      mdl_cnt0 = '0;
      mdl_cnt1 = '0;
    end else if (gv && r.err) begin
      if (!g && mdl_cnt0 != '1) mdl_cnt0 = mdl_cnt0 + 1'b1;
      if (g && mdl_cnt1 != '1)  mdl_cnt1 = mdl_cnt1 + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_exp = 1'b0; bus.in0_odd = 1'b0;
    bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_exp = 1'b0; bus.in1_odd = 1'b0;
    bus.out_ready = 1'b0; bus.cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 00010",
               {bus.out_valid, bus.out_ch, bus.out_ep, bus.out_op, bus.out_err});
    end
    tests_run++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b required 00", {bus.in0_ready, bus.in1_ready});
    end
`ifdef PARITY_ERR_CNT_EN
    tests_run++;
    if ({bus.err_cnt0, bus.err_cnt1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %h/%h required 0/0", bus.err_cnt0, bus.err_cnt1);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 9'h001; bus.in0_odd = 1'b0; bus.in0_exp = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got %b required 10", {bus.in0_ready, bus.in1_ready});
    end
    tick();
    bus.in0_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== 5'b10100) begin
      tests_failed++;
      $display("FAIL single_result: got %b required 10100",
               {bus.out_valid, bus.out_ch, bus.out_ep, bus.out_op, bus.out_err});
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: out_valid got %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      bus.in0_valid = (i < 6); bus.in1_valid = (i < 6);
      bus.in0_data = 9'($urandom); bus.in0_odd = 1'($urandom); bus.in0_exp = 1'($urandom);
      bus.in1_data = 9'($urandom); bus.in1_odd = 1'($urandom); bus.in1_exp = 1'($urandom);
      #1;
      if (i < 6) begin
        tests_run++;
        if ({bus.in0_ready, bus.in1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          tests_failed++;
          $display("FAIL alt_grant[%0d]: got %b required %b", i, {bus.in0_ready, bus.in1_ready},
                   (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (i > 0) begin
        tests_run++;
        if (!bus.out_valid || exp_q.size() == 0 || bus.out_ch !== 1'((i - 1) % 2) ||
            {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL alt_result[%0d]: got v=%b %b required v=1 %b", i, bus.out_valid,
                   {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err},
                   (exp_q.size() > 0) ? exp_q[0] : 4'bxxxx);
        end
      end
      tick();
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_drain: out_valid got %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    res_t held;
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 9'h0A5; bus.in0_odd = 1'b1; bus.in0_exp = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    held = exp_q[0];
    bus.out_ready = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = 9'h13C; bus.in1_odd = 1'b0; bus.in1_exp = 1'b0;
    bus.in0_data = 9'h1FF;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00 || bus.out_valid !== 1'b1 ||
          {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== held) begin
        tests_failed++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b res=%b required rdy=00 v=1 res=%b", i,
                 {bus.in0_ready, bus.in1_ready}, bus.out_valid,
                 {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err}, held);
      end
      tick();
    end
    bus.in0_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: in1_ready got %b required 1", bus.in1_ready);
    end
    tick();
    bus.in1_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || exp_q.size() != 1 || bus.out_ch !== 1'b1 ||
        {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL b2b_result: got v=%b %b required v=1 ch=1 %b", bus.out_valid,
               {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err},
               (exp_q.size() > 0) ? exp_q[0] : 4'bxxxx);
    end
    tick();
  endtask

  task automatic test_ch1_err();
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 9'h1FF; bus.in1_odd = 1'b1; bus.in1_exp = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in1_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_ch, bus.out_ep, bus.out_op, bus.out_err} !== 4'b1101 ||
        exp_q.size() == 0 || exp_q[0] !== 4'b1101) begin
      tests_failed++;
      $display("FAIL ch1_err: got %b required 1101",
               {bus.out_ch, bus.out_ep, bus.out_op, bus.out_err});
    end
`ifdef PARITY_ERR_CNT_EN
    tests_run++;
    if (bus.err_cnt1 !== 2'd1 || bus.err_cnt1 !== mdl_cnt1) begin
      tests_failed++;
      $display("FAIL ch1_cnt: got %0d required 1", bus.err_cnt1);
    end
`endif
    tick();
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_saturate();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in0_data = 9'h000; bus.in0_odd = 1'b0; bus.in0_exp = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      bus.in0_valid = 1'b1;
      #1;
      tick();
    end
    bus.in0_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.err_cnt0 !== 2'd3 || bus.err_cnt0 !== mdl_cnt0) begin
      tests_failed++;
      $display("FAIL cnt_sat: got %0d required 3", bus.err_cnt0);
    end
    bus.in0_valid = 1'b1;
    bus.cnt_clr = 1'b1;
    tick();
    bus.in0_valid = 1'b0;
    bus.cnt_clr = 1'b0;
    #1;
    tests_run++;
    if (bus.err_cnt0 !== 2'd0 || bus.err_cnt1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL cnt_clr: got %0d/%0d required 0/0", bus.err_cnt0, bus.err_cnt1);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_hold();
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 9'h000; bus.in1_odd = 1'b0; bus.in1_exp = 1'b1;
    tick();
    bus.in1_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_op !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b op=%b required v=0 op=1", bus.out_valid, bus.out_op);
    end
`ifdef PARITY_ERR_CNT_EN
    tests_run++;
    if (bus.err_cnt1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset_cnt: got %0d required 0", bus.err_cnt1);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.in0_valid = 1'b1; bus.in1_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got %b required 10", {bus.in0_ready, bus.in1_ready});
    end
    tick();
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_ch: got v=%b ch=%b required v=1 ch=0", bus.out_valid, bus.out_ch);
    end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_ch1_err();
`ifdef PARITY_ERR_CNT_EN
    test_saturate();
`endif
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/parity_arb_2ch.md
# parity_arb_2ch

Two-channel round-robin arbiter and sequencer for a shared 9-bit parity generator/checker. Each requester presents a 9-bit word, an expected parity bit and an even/odd select. The block grants one requester per transaction, computes even/odd parity on the shared XOR tree, and compares the result against the expected bit. It registers the result with a channel tag behind a valid/ready handshake, and optionally keeps per-channel saturating error counters. It sits between the frame receive logic and the error-reporting/status block.

## Interface
Parameters:
- CNT_W, 8, width of each error counter (only used when the counter feature is compiled in)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in0_valid  input  1  channel 0 request valid
- in0_ready  output  1  channel 0 accepted this cycle
- in0_data  input  9  channel 0 word
- in0_exp  input  1  channel 0 expected parity bit
- in0_odd  input  1  channel 0 parity sense: 1 = odd, 0 = even
- in1_valid, in1_ready, in1_data, in1_exp, in1_odd: same as channel 0, for channel 1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_ch  output  1  channel that produced the result
- out_ep  output  1  even-parity bit of the word (XOR of all 9 bits)
- out_op  output  1  odd-parity bit (~out_ep)
- out_err  output  1  1 = selected parity ≠ expected bit
- cnt_clr  input  1  synchronous clear of both error counters
- err_cnt0  output  CNT_W  channel 0 error count (feature only)
- err_cnt1  output  CNT_W  channel 1 error count (feature only)

## Operation
- FSM states:
  - IDLE (out_valid=0)
  - HOLD (out_valid=1, result registers stable)
- Accept condition: `can_accept = (state==IDLE) | out_ready`.
- Grant, combinational from valids and `last_grant`:
  - only in0_valid → channel 0
  - only in1_valid → channel 1
  - both valid → channel ≠ last_grant
  - none valid → no grant
- `inN_ready = can_accept & grant==N`. At most one ready is high per cycle; ready is 0 for a channel without valid.
- On accept (ready & valid of the granted channel):
  - out_ch ← grant
  - out_ep ← ^data
  - out_op ← ~^data
  - out_err ← ((odd ? ~^data : ^data) ≠ exp)
  - last_grant ← grant
  - state → HOLD
- HOLD with out_ready and no new accept → IDLE.
- HOLD with out_ready and a new accept → stay in HOLD, load the new result (back-to-back, one result per cycle).
- HOLD without out_ready: all result registers hold, both readies stay 0.
- Requester data need only be stable in the accept cycle.

## Timing
- Reset (async, asserts immediately) values:
  - state=IDLE, out_valid=0, out_ch=0, out_ep=0, out_op=1, out_err=0
  - last_grant=1, so channel 0 wins the first contention
  - counters=0
- Latency: accept at edge N → out_valid=1 with the result after edge N; visible in cycle N+1.
- Throughput: 1 result/cycle while out_ready is held high. Under continuous dual requests, grants alternate 0,1,0,1…
- Readies depend combinationally on the valids, state and out_ready. There is no combinational path from any data input to out_*.
- Reset asserted mid-HOLD drops out_valid immediately. The pending result is lost and no counter update occurs.

## Configuration
- PARITY_ERR_CNT_EN defined:
  - err_cnt0/err_cnt1 are present.
  - On each accept with computed err=1, the granted channel's counter increments, saturating at 2^CNT_W−1.
  - cnt_clr clears both counters in the next cycle and wins over a simultaneous increment.
- PARITY_ERR_CNT_EN undefined:
  - No counter registers are built.
  - err_cnt0/err_cnt1 ports are omitted.
  - cnt_clr is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then in0_valid with data=9'h001, odd=0, exp=1, out_ready=1 → in0_ready=1; next cycle out_valid=1, out_ch=0, out_ep=1, out_op=0, out_err=0.
- Both valid every cycle, out_ready=1, 6 cycles → grants 0,1,0,1,0,1; out_ch sequence matches, one cycle later.
- Result pending with out_ready=0 for 3 cycles → both readies 0, out_* stable; raise out_ready with in1_valid high → back-to-back accept, out_valid stays 1, out_ch=1.
- Channel 1 data=9'h1FF, odd=1, exp=1 → out_ep=1, out_op=0, out_err=1; with PARITY_ERR_CNT_EN, err_cnt1=1.
- With PARITY_ERR_CNT_EN and CNT_W=2, five erroring channel 0 transfers → err_cnt0 saturates at 3; cnt_clr asserted together with a sixth error → err_cnt0=0.
- Assert rst while out_valid=1 → out_valid=0 and out_op=1 immediately; first post-reset contention grants channel 0.
